dcp_dump: RTL
=============

DCP_DUMP -- requirements
Module: dcp_dump

Interface
REQ-001 SHALL have parameter NREG, default 9, meaning number of dumpable registers (range 1..64).
REQ-002 SHALL have parameter DW, default 32, meaning register and dout width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle request to begin a dump.
REQ-006 SHALL have port abort, input, 1, meaning terminate the dump in progress.
REQ-007 SHALL have port reg_mask, input, NREG, meaning bit i=1 selects register i.
REQ-008 SHALL have port regs, input, NREG*DW, meaning flat register vector; register i is at bits [i*DW +: DW].
REQ-009 SHALL have port ack_tx, input, 1, meaning the transmitter acknowledge.
REQ-010 SHALL have port req_tx, output, 1, meaning the transfer request.
REQ-011 SHALL have port type_tx, output, 2, meaning transfer type: 00 HDR, 01 DATA, 10 END.
REQ-012 SHALL have port dout, output, DW, meaning the transfer payload.
REQ-013 SHALL have port busy, output, 1, meaning high whenever state is not IDLE.
REQ-014 SHALL have port finish, output, 1, meaning a one-cycle pulse on normal completion.

Function
REQ-015 SHALL implement states IDLE, SCAN, HDR_REQ, HDR_WAIT, DAT_REQ, DAT_WAIT, END_REQ, END_WAIT.
REQ-016 SHALL, in IDLE with start=1, capture regs into a snapshot and reg_mask into a mask latch, clear idx to 0, and enter SCAN.
REQ-017 SHALL, in SCAN, do one of: go to HDR_REQ if mask[idx]=1; else increment idx if idx<NREG-1; else go to END_REQ. Each skipped index costs exactly one cycle.
REQ-018 SHALL hold req_tx=1 in every *_REQ state, with type_tx and dout stable for the whole request.
REQ-019 SHALL leave each *_REQ state for the matching *_WAIT state on the first cycle ack_tx=1 is sampled; req_tx deasserts in the following cycle.
REQ-020 SHALL leave each *_WAIT state only when ack_tx=0 is sampled (4-phase handshake).
REQ-021 SHALL drive HDR payload as dout = idx zero-extended to DW, with type_tx = 00.
REQ-022 SHALL drive DATA payload as dout = snapshot[idx], with type_tx = 01.
REQ-023 SHALL transition HDR_WAIT -> DAT_REQ.
REQ-024 SHALL transition DAT_WAIT -> SCAN with idx+1 when idx<NREG-1, otherwise -> END_REQ.
REQ-025 SHALL drive END payload as dout = 0, with type_tx = 10.
REQ-026 SHALL, from END_WAIT, go to IDLE and pulse finish=1 for exactly one cycle.
REQ-027 SHALL give start-to-first-req latency of 2 cycles when mask[0]=1, plus 1 cycle per leading unselected index.
REQ-028 SHALL ignore start while busy=1; the snapshot and mask remain unchanged.
REQ-029 SHALL ignore ack_tx in IDLE and SCAN.
REQ-030 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with req_tx=0 and no finish; abort has priority over ack_tx.
REQ-031 SHALL, when start and abort are both high in IDLE, ignore abort and start the dump.
REQ-032 SHALL, for mask all zero, emit only the END transfer after NREG SCAN cycles.
REQ-033 SHALL size idx at max(1,clog2(NREG)) bits so that it never wraps.

Reset
REQ-034 SHALL, on rst=1, set state to IDLE, and clear req_tx, type_tx, dout, busy, finish, idx, snapshot and mask.
REQ-035 SHALL give rst priority over start, abort and ack_tx, including mid-handshake; no finish pulse results.

Structure
REQ-036 SHALL place the state encoding and type_tx codes (TX_HDR, TX_DATA, TX_END) in package dcp_pkg, shared with the other DCP blocks.
REQ-037 SHALL register all outputs, with no combinational path from ack_tx to req_tx.
REQ-038 SHALL be a single module; a handshake sub-module is not warranted.

Verification
REQ-039 SHALL cover full dump: NREG=9, regs 1..9, mask 0x1FF, ack pulses 5 cycles high / 5 low -> 19 transfers (HDR 0, DATA 1, ... HDR 8, DATA 9, END), then one finish pulse.
REQ-040 SHALL cover sparse dump: mask 0x104 -> HDR 2, DATA 3, HDR 8, DATA 9, END; first req_tx rises 4 cycles after start.
REQ-041 SHALL cover snapshot: change all regs to 0xFFFFFFFF one cycle after start -> DATA payloads are still 1..9.
REQ-042 SHALL cover abort: assert abort during the 3rd transfer's REQ with ack_tx=1 -> IDLE next cycle, req_tx=0, busy=0, finish never pulses.
REQ-043 SHALL cover empty mask and busy start: mask 0 -> only END, after 9 SCAN cycles; a second start while busy produces no extra transfers.
REQ-044 SHALL cover reset: rst asserted in DAT_WAIT -> all outputs 0 next cycle; a new start afterwards performs a clean dump.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared DCP definitions: dump FSM state encoding and transfer type codes.
// Other DCP blocks decode type_tx with the same constants.
package dcp_pkg;

   typedef logic [2:0] dcp_state_t;

   localparam dcp_state_t ST_IDLE     = 3'd0;
   localparam dcp_state_t ST_SCAN     = 3'd1;
   localparam dcp_state_t ST_HDR_REQ  = 3'd2;
   localparam dcp_state_t ST_HDR_WAIT = 3'd3;
   localparam dcp_state_t ST_DAT_REQ  = 3'd4;
   localparam dcp_state_t ST_DAT_WAIT = 3'd5;
   localparam dcp_state_t ST_END_REQ  = 3'd6;
   localparam dcp_state_t ST_END_WAIT = 3'd7;

   typedef logic [1:0] dcp_tx_t;

   localparam dcp_tx_t TX_HDR  = 2'b00;
   localparam dcp_tx_t TX_DATA = 2'b01;
   localparam dcp_tx_t TX_END  = 2'b10;

   function automatic logic is_req_state(input dcp_state_t s);
      return (s == ST_HDR_REQ) || (s == ST_DAT_REQ) || (s == ST_END_REQ);
   endfunction

endpackage

// File: rtl/dcp_dump.sv
// Register dump engine: snapshots a register bank on start and streams
// HDR/DATA pairs for each selected register, then END, over a req/ack link.
module dcp_dump
   import dcp_pkg::*;
#(
   parameter int NREG = 9,
   parameter int DW   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [NREG-1:0]    reg_mask,
   input  logic [NREG*DW-1:0] regs,
   input  logic               ack_tx,
   output logic               req_tx,
   output logic [1:0]         type_tx,
   output logic [DW-1:0]      dout,
   output logic               busy,
   output logic               finish
);

   localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

   dcp_state_t         state, state_nxt;
   logic [IW-1:0]      idx, idx_nxt;
   logic [NREG*DW-1:0] snap;
   logic [NREG-1:0]    mask;
   dcp_tx_t            type_nxt;
   logic [DW-1:0]      dout_nxt;
   logic               finish_nxt;

   // Link protocol (4-phase): req_tx rises with type_tx/dout already valid and
   // holds them until ack_tx is sampled high; req_tx then drops, and the next
   // request may only start once ack_tx has been sampled low again.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SCAN;
               idx_nxt   = '0;
            end
         end
         ST_SCAN: begin
            if (mask[idx])
               state_nxt = ST_HDR_REQ;
            else if (idx != LAST_IDX)
               idx_nxt = idx + IW'(1);
            else
               state_nxt = ST_END_REQ;
         end
         ST_HDR_REQ:  if (ack_tx)  state_nxt = ST_HDR_WAIT;
         ST_HDR_WAIT: if (!ack_tx) state_nxt = ST_DAT_REQ;
         ST_DAT_REQ:  if (ack_tx)  state_nxt = ST_DAT_WAIT;
         ST_DAT_WAIT: begin
            if (!ack_tx) begin
               if (idx != LAST_IDX) begin
                  state_nxt = ST_SCAN;
                  idx_nxt   = idx + IW'(1);
               end else begin
                  state_nxt = ST_END_REQ;
               end
            end
         end
         ST_END_REQ:  if (ack_tx)  state_nxt = ST_END_WAIT;
         ST_END_WAIT: if (!ack_tx) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
      // Abort wins over ack_tx; in IDLE it is ignored so start always wins.
      if (abort && (state != ST_IDLE))
         state_nxt = ST_IDLE;
   end

   // Outputs are registered from the next state so payload is valid the
   // same cycle req_tx rises.
   always_comb begin
      type_nxt = TX_HDR;
      dout_nxt = '0;
      case (state_nxt)
         ST_HDR_REQ, ST_HDR_WAIT: begin
            type_nxt = TX_HDR;
            dout_nxt = DW'(idx_nxt);
         end
         ST_DAT_REQ, ST_DAT_WAIT: begin
            type_nxt = TX_DATA;
            dout_nxt = snap[idx_nxt*DW +: DW];
         end
         ST_END_REQ, ST_END_WAIT: begin
            type_nxt = TX_END;
            dout_nxt = '0;
         end
         default: begin
            type_nxt = TX_HDR;
            dout_nxt = '0;
         end
      endcase
      finish_nxt = (state == ST_END_WAIT) && !ack_tx && !abort;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         snap    <= '0;
         mask    <= '0;
         req_tx  <= 1'b0;
         type_tx <= '0;
         dout    <= '0;
         busy    <= 1'b0;
         finish  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if ((state == ST_IDLE) && start) begin
            snap <= regs;
            mask <= reg_mask;
         end
         req_tx  <= is_req_state(state_nxt);
         type_tx <= type_nxt;
         dout    <= dout_nxt;
         busy    <= (state_nxt != ST_IDLE);
         finish  <= finish_nxt;
      end
   end

endmodule
